lcd_ci_controller: RTL and testbench
====================================

Name: lcd_ci_controller

Overview:
Parametrised HD44780-class character-LCD driver exposed as a Nios II multicycle custom instruction (clk/clk_en/reset/start/done/dataa/datab/result).
- Each issued instruction writes one byte to the LCD, as a command or display data.
- The block generates RS/RW/EN/data pin timing in clock cycles, including the controller execution wait, and asserts done when the LCD is ready for the next access.
- Supports 8-bit and 4-bit (two-nibble) bus modes; replaces the previous pass-through command decoder.

Parameters:
BUS_4BIT, 0, 0 = 8-bit bus transfer; 1 = two nibble transfers (high nibble first) on lcd_data[7:4].
SETUP_CYC, 4, cycles RS/data stable before EN rises (>=1).
EN_CYC, 12, cycles EN held high per transfer (>=1).
HOLD_CYC, 4, cycles RS/data held after EN falls (>=1).
CMD_WAIT_CYC, 2000, execution wait after normal command/data byte (>=1).
CLEAR_WAIT_CYC, 80000, execution wait after Clear Display (0x01) or Return Home (0x02) with RS=0 (>=1).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_en  in  1  custom-instruction clock enable; all state and counters freeze when low
start  in  1  one-cycle instruction issue strobe
dataa  in  32  bit0 = RS (0 command, 1 data); bits 31:1 ignored
datab  in  32  bits 7:0 = byte to write; bits 31:8 ignored
done  out  1  one-cycle completion strobe
result  out  32  {23'b0, RS, byte} of completed transfer
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write; constant 0 (write only)
lcd_en  out  1  LCD enable strobe
lcd_data  out  8  LCD data bus; [3:0] driven 0 when BUS_4BIT=1

Behaviour:
- Reset is clock-qualified by clk only, not by clk_en. At reset: state IDLE; done=0, result=0, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=0, counters=0.
- All transitions below occur only on edges where clk_en=1.
- IDLE:
  - On start=1, latch RS=dataa[0] and byte=datab[7:0].
  - Select wait: CLEAR_WAIT_CYC if RS=0 and byte is 0x01 or 0x02, else CMD_WAIT_CYC.
  - Drive lcd_rs, and lcd_data with the byte (8-bit) or {byte[7:4],4'b0} (4-bit).
  - Go to SETUP.
- SETUP: EN=0 for SETUP_CYC cycles -> EN_HI.
- EN_HI: lcd_en=1 for EN_CYC cycles -> HOLD (lcd_en=0 on exit).
- HOLD: EN=0, data/RS held for HOLD_CYC cycles.
  - 4-bit mode, first nibble: load {byte[3:0],4'b0}, go to SETUP.
  - Otherwise go to WAIT.
- WAIT: count the selected wait -> DONE.
- DONE: done=1 and result={23'b0,RS,byte} for exactly one cycle -> IDLE. lcd_data/lcd_rs keep their last value in IDLE.
- Latency: L = SETUP_CYC+EN_CYC+HOLD_CYC+WAIT (8-bit), or 2*(SETUP_CYC+EN_CYC+HOLD_CYC)+WAIT (4-bit). With start sampled in cycle 0 and clk_en continuously high, done is high in cycle L+1 only.
- start while not IDLE is ignored (no queueing, no state change). start in the DONE cycle is ignored; a new start is accepted from the IDLE cycle after done.
- clk_en low in any state: counters, state, outputs and done frozen. A done pulse extends while clk_en is low; it deasserts on the first enabled edge.
- reset mid-transfer: next edge returns to IDLE, lcd_en=0, no done for the aborted transfer.
- Counter width: $clog2 of max(SETUP_CYC, EN_CYC, HOLD_CYC, CMD_WAIT_CYC, CLEAR_WAIT_CYC)+1. Each phase counts exactly its parameter value, with no off-by-one.
- result holds its value between completions.

Test Plan:
(Bench parameters: SETUP_CYC=2, EN_CYC=4, HOLD_CYC=2, CMD_WAIT_CYC=10, CLEAR_WAIT_CYC=50; clk_en=1 unless stated.)
- 8-bit command: BUS_4BIT=0, start with dataa=0, datab=0x38 -> lcd_rs=0, lcd_data=0x38; lcd_en high for exactly 4 cycles starting 2 cycles after SETUP entry; done in cycle 19 only; result=0x038.
- Clear wait: dataa=0, datab=0x01 -> done in cycle 59; RS=1 with datab=0x01 (data byte) -> done in cycle 19; result=0x101.
- 4-bit data write: BUS_4BIT=1, dataa=1, datab=0x4A -> two EN pulses of 4 cycles, lcd_data=0x40 then 0xA0, lcd_rs=1 throughout; done in cycle 27; result=0x14A.
- Busy rejection: second start with datab=0x55 issued at cycle 5 of a 0x38 transfer -> ignored, single done at cycle 19, result=0x038. New start in the cycle after done -> accepted.
- clk_en stall: drop clk_en for 7 cycles during EN_HI -> lcd_en stays high; done delayed by exactly 7 cycles (cycle 26). clk_en low during done -> done held until re-enabled.
- Reset mid-op: assert reset during WAIT of a 0x02 command -> next cycle state IDLE, lcd_en=0, done never pulses; a subsequent 0x38 command completes normally in 19 cycles.

Source files
------------

// File: rtl/lcd_ci_controller.sv
// HD44780-class character LCD writer as a Nios II multicycle custom
// instruction: one command/data byte per instruction, 8- or 4-bit bus.
module lcd_ci_controller #(
    parameter int BUS_4BIT       = 0,
    parameter int SETUP_CYC      = 4,
    parameter int EN_CYC         = 12,
    parameter int HOLD_CYC       = 4,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 80000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic [7:0]  lcd_data
);

    localparam int MAX_SE  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_SEH = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
    localparam int MAX_W   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ?
                             CMD_WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_CYC = (MAX_SEH > MAX_W) ? MAX_SEH : MAX_W;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, last_cnt;
    logic          phase_end;
    logic          rs_q, rs_d;
    logic          clear_q, clear_d;
    logic          lo_q, lo_d;
    logic          en_q, en_d;
    logic          done_q, done_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    data_q, data_d;
    logic [31:0]   result_q, result_d;
    logic          unused_bits;

    always_comb begin
        case (state_q)
            S_SETUP: last_cnt = SETUP_LAST;
            S_EN_HI: last_cnt = EN_LAST;
            S_HOLD:  last_cnt = HOLD_LAST;
            S_WAIT:  last_cnt = clear_q ? CLEAR_LAST : CMD_LAST;
            default: last_cnt = '0;
        endcase
        phase_end = (cnt_q == last_cnt);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs_d     = rs_q;
        clear_d  = clear_q;
        lo_d     = lo_q;
        en_d     = en_q;
        done_d   = done_q;
        byte_d   = byte_q;
        data_d   = data_q;
        result_d = result_q;
        // Holding every _d at its _q while clk_en is low freezes the block.
        if (clk_en) begin
            cnt_d = phase_end ? '0 : cnt_q + CW'(1);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rs_d    = dataa[0];
                        byte_d  = datab[7:0];
                        clear_d = !dataa[0] &&
                                  (datab[7:0] == 8'h01 || datab[7:0] == 8'h02);
                        data_d  = (BUS_4BIT != 0) ?
                                  {datab[7:4], 4'h0} : datab[7:0];
                        lo_d    = 1'b0;
                        state_d = S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase_end) begin
                        en_d    = 1'b1;
                        state_d = S_EN_HI;
                    end
                end
                S_EN_HI: begin
                    if (phase_end) begin
                        en_d    = 1'b0;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (phase_end) begin
                        if (BUS_4BIT != 0 && !lo_q) begin
                            lo_d    = 1'b1;
                            data_d  = {byte_q[3:0], 4'h0};
                            state_d = S_SETUP;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (phase_end) begin
                        done_d   = 1'b1;
                        result_d = {23'b0, rs_q, byte_q};
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rs_q     <= 1'b0;
            clear_q  <= 1'b0;
            lo_q     <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            byte_q   <= '0;
            data_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs_q     <= rs_d;
            clear_q  <= clear_d;
            lo_q     <= lo_d;
            en_q     <= en_d;
            done_q   <= done_d;
            byte_q   <= byte_d;
            data_q   <= data_d;
            result_q <= result_d;
        end
    end

    assign done        = done_q;
    assign result      = result_q;
    assign lcd_rs      = rs_q;
    assign lcd_rw      = 1'b0;
    assign lcd_en      = en_q;
    assign lcd_data    = data_q;
    assign unused_bits = ^{dataa[31:1], datab[31:8]};

endmodule

// File: tb/tb_lcd_ci_controller.sv
// Bench for lcd_ci_controller: one 8-bit and one 4-bit instance, directed
// scenarios plus random writes checked against a cycle-position model.
module tb_lcd_ci_controller;

    localparam int S    = 2;
    localparam int E    = 4;
    localparam int H    = 2;
    localparam int CMDW = 10;
    localparam int CLRW = 50;
    localparam int T    = S + E + H;
    localparam int MAXC = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce8, st8, ce4, st4;
    logic [31:0] a8, b8, a4, b4;
    logic        dn8, rs8, rw8, en8, dn4, rs4, rw4, en4;
    logic [31:0] res8, res4;
    logic [7:0]  dat8, dat4;

    lcd_ci_controller #(
        .BUS_4BIT(0), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
        .CMD_WAIT_CYC(CMDW), .CLEAR_WAIT_CYC(CLRW)
    ) u8 (
        .clk(clk), .reset(reset), .clk_en(ce8), .start(st8),
        .dataa(a8), .datab(b8), .done(dn8), .result(res8),
        .lcd_rs(rs8), .lcd_rw(rw8), .lcd_en(en8), .lcd_data(dat8)
    );

    lcd_ci_controller #(
        .BUS_4BIT(1), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
        .CMD_WAIT_CYC(CMDW), .CLEAR_WAIT_CYC(CLRW)
    ) u4 (
        .clk(clk), .reset(reset), .clk_en(ce4), .start(st4),
        .dataa(a4), .datab(b4), .done(dn4), .result(res4),
        .lcd_rs(rs4), .lcd_rw(rw4), .lcd_en(en4), .lcd_data(dat4)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        en_tr [0:MAXC];
    logic [7:0]  d_tr  [0:MAXC];
    logic        rs_tr [0:MAXC];
    logic        rw_tr [0:MAXC];
    int          done_cyc [$];
    logic [31:0] done_res [$];
    int          inj_at [2];
    logic [7:0]  inj_byte [2];
    int          stall_at, stall_len, rst_at;

    // Reference model: expectations derived from cycle position only.
    function automatic int nibbles(input bit m4);
        return m4 ? 2 : 1;
    endfunction

    function automatic int latency(input bit m4, input bit rs,
                                   input logic [7:0] b);
        int w;
        w = (!rs && (b == 8'h01 || b == 8'h02)) ? CLRW : CMDW;
        return nibbles(m4) * T + w;
    endfunction

    function automatic bit exp_en(input bit m4, input int c);
        int k;
        k = c - 1;
        return (k < nibbles(m4) * T) && (k % T >= S) && (k % T < S + E);
    endfunction

    function automatic logic [7:0] exp_data(input bit m4,
                                            input logic [7:0] b,
                                            input int c);
        if (!m4) return b;
        if (c > T) return {b[3:0], 4'h0};
        return {b[7:4], 4'h0};
    endfunction

    task automatic clear_ctl();
        inj_at[0] = -1;
        inj_at[1] = -1;
        stall_at  = -1;
        stall_len = 0;
        rst_at    = -1;
        done_cyc.delete();
        done_res.delete();
    endtask

    task automatic drive(input bit m4, input bit st, input bit rs,
                         input logic [7:0] b);
        logic [31:0] ra, rb;
        ra = $urandom();
        rb = $urandom();
        ra[0] = rs;
        rb[7:0] = b;
        if (m4) begin
            st4 = st; a4 = ra; b4 = rb;
        end else begin
            st8 = st; a8 = ra; b8 = rb;
        end
    endtask

    task automatic set_ce(input bit m4, input bit v);
        if (m4) ce4 = v;
        else ce8 = v;
    endtask

    // Start is driven in cycle 0; cycle c is sampled at the c-th negedge.
    task automatic run(input bit m4, input bit rs, input logic [7:0] b,
                       input int ncyc);
        logic        dn;
        logic [31:0] r;
        @(negedge clk);
        drive(m4, 1'b1, rs, b);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (m4) begin
                en_tr[c] = en4; d_tr[c] = dat4; rs_tr[c] = rs4;
                rw_tr[c] = rw4; dn = dn4; r = res4;
            end else begin
                en_tr[c] = en8; d_tr[c] = dat8; rs_tr[c] = rs8;
                rw_tr[c] = rw8; dn = dn8; r = res8;
            end
            if (dn === 1'b1) begin
                done_cyc.push_back(c);
                done_res.push_back(r);
            end
            if (c == 1) drive(m4, 1'b0, 1'b0, 8'h00);
            for (int i = 0; i < 2; i++) begin
                if (c == inj_at[i]) drive(m4, 1'b1, 1'b0, inj_byte[i]);
                if (c == inj_at[i] + 1) drive(m4, 1'b0, 1'b0, 8'h00);
            end
            if (c == stall_at) set_ce(m4, 1'b0);
            if (c == stall_at + stall_len) set_ce(m4, 1'b1);
            if (c == rst_at) reset = 1'b1;
            if (c == rst_at + 1) reset = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce8 = 1'b0;
        ce4 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dn8, res8, rs8, rw8, en8, dat8} !== 44'h0) begin
            errors++;
            $display("FAIL reset8: got %h expected 0",
                     {dn8, res8, rs8, rw8, en8, dat8});
        end
        checks++;
        if ({dn4, res4, rs4, rw4, en4, dat4} !== 44'h0) begin
            errors++;
            $display("FAIL reset4: got %h expected 0",
                     {dn4, res4, rs4, rw4, en4, dat4});
        end
        reset = 1'b0;
        ce8 = 1'b1;
        ce4 = 1'b1;
    endtask

    task automatic test_cmd8();
        int bad;
        clear_ctl();
        run(1'b0, 1'b0, 8'h38, 23);
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 19) begin
            errors++;
            $display("FAIL cmd8_done: got %0d pulses first %0d expected 1 at 19",
                     done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
        end
        checks++;
        if (done_res.size() == 0 || done_res[0] !== 32'h038) begin
            errors++;
            $display("FAIL cmd8_result: got %h expected 00000038",
                     done_res.size() ? done_res[0] : 32'hx);
        end
        bad = 0;
        for (int c = 1; c <= 23; c++) begin
            if (en_tr[c] !== (c >= 3 && c <= 6)) bad++;
            if (d_tr[c] !== 8'h38 || rs_tr[c] !== 1'b0) bad++;
            if (rw_tr[c] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cmd8_pins: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_clear_wait();
        clear_ctl();
        run(1'b0, 1'b0, 8'h01, 62);
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 59) begin
            errors++;
            $display("FAIL clear_done: got %0d pulses first %0d expected 1 at 59",
                     done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
        end
        clear_ctl();
        run(1'b0, 1'b1, 8'h01, 22);
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 19) begin
            errors++;
            $display("FAIL data01_done: got %0d pulses first %0d expected 1 at 19",
                     done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
        end
        checks++;
        if (done_res.size() == 0 || done_res[0] !== 32'h101) begin
            errors++;
            $display("FAIL data01_result: got %h expected 00000101",
                     done_res.size() ? done_res[0] : 32'hx);
        end
    endtask

    task automatic test_4bit();
        int bad;
        clear_ctl();
        run(1'b1, 1'b1, 8'h4A, 30);
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 27) begin
            errors++;
            $display("FAIL nib_done: got %0d pulses first %0d expected 1 at 27",
                     done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
        end
        checks++;
        if (done_res.size() == 0 || done_res[0] !== 32'h14A) begin
            errors++;
            $display("FAIL nib_result: got %h expected 0000014a",
                     done_res.size() ? done_res[0] : 32'hx);
        end
        bad = 0;
        for (int c = 1; c <= 27; c++) begin
            if (en_tr[c] !== (c inside {[3:6], [11:14]})) bad++;
            if (rs_tr[c] !== 1'b1) bad++;
            if (d_tr[c] !== ((c <= 8) ? 8'h40 : 8'hA0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL nib_pins: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_busy();
        clear_ctl();
        inj_at[0] = 5;
        inj_byte[0] = 8'h55;
        inj_at[1] = 20;
        inj_byte[1] = 8'h0C;
        run(1'b0, 1'b0, 8'h38, 42);
        checks++;
        if (done_cyc.size() != 2 || done_cyc[0] != 19 || done_cyc[1] != 39) begin
            errors++;
            $display("FAIL busy_done: got %0d pulses first %0d expected 19,39",
                     done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
        end
        checks++;
        if (done_res.size() != 2 || done_res[0] !== 32'h038 ||
            done_res[1] !== 32'h00C) begin
            errors++;
            $display("FAIL busy_result: got %h expected 00000038 then 0000000c",
                     done_res.size() ? done_res[0] : 32'hx);
        end
        checks++;
        if (d_tr[15] !== 8'h38) begin
            errors++;
            $display("FAIL busy_data: got %h expected 38", d_tr[15]);
        end
    endtask

    task automatic test_stall();
        int hi, last;
        clear_ctl();
        stall_at = 4;
        stall_len = 7;
        run(1'b0, 1'b0, 8'h38, 30);
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 26) begin
            errors++;
            $display("FAIL stall_done: got %0d pulses first %0d expected 1 at 26",
                     done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
        end
        hi = 0;
        last = -1;
        for (int c = 1; c <= 30; c++) begin
            if (en_tr[c] === 1'b1) begin
                hi++;
                last = c;
            end
        end
        checks++;
        if (hi != 11 || last != 13) begin
            errors++;
            $display("FAIL stall_en: got %0d high ending %0d expected 11 ending 13",
                     hi, last);
        end
        clear_ctl();
        stall_at = 19;
        stall_len = 3;
        run(1'b0, 1'b0, 8'h38, 26);
        checks++;
        if (done_cyc.size() != 4 || done_cyc[0] != 19 || done_cyc[3] != 22) begin
            errors++;
            $display("FAIL stall_done_hold: got %0d cycles expected 4 (19..22)",
                     done_cyc.size());
        end
    endtask

    task automatic test_reset_midop();
        clear_ctl();
        rst_at = 20;
        run(1'b0, 1'b0, 8'h02, 80);
        checks++;
        if (done_cyc.size() != 0) begin
            errors++;
            $display("FAIL abort_done: got %0d pulses expected 0", done_cyc.size());
        end
        checks++;
        if (en_tr[21] !== 1'b0 || d_tr[21] !== 8'h00) begin
            errors++;
            $display("FAIL abort_pins: got en %b data %h expected 0 00",
                     en_tr[21], d_tr[21]);
        end
        clear_ctl();
        run(1'b0, 1'b0, 8'h38, 22);
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 19) begin
            errors++;
            $display("FAIL after_abort: got %0d pulses first %0d expected 1 at 19",
                     done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
        end
    endtask

    task automatic test_random();
        bit         m4, rs;
        logic [7:0] b;
        int         lat, bad;
        for (int n = 0; n < 12; n++) begin
            m4 = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            b = 8'($urandom());
            if ($urandom_range(0, 2) == 0) b = 8'($urandom_range(1, 2));
            lat = latency(m4, rs, b);
            clear_ctl();
            run(m4, rs, b, lat + 3);
            checks++;
            if (done_cyc.size() != 1 || done_cyc[0] != lat + 1) begin
                errors++;
                $display("FAIL rand_done: got %0d pulses first %0d expected 1 at %0d",
                         done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, lat + 1);
            end
            checks++;
            if (done_res.size() == 0 || done_res[0] !== {23'b0, rs, b}) begin
                errors++;
                $display("FAIL rand_result: got %h expected %h",
                         done_res.size() ? done_res[0] : 32'hx, {23'b0, rs, b});
            end
            bad = 0;
            for (int c = 1; c <= lat + 1; c++) begin
                if (en_tr[c] !== exp_en(m4, c)) bad++;
                if (d_tr[c] !== exp_data(m4, b, c)) bad++;
                if (rs_tr[c] !== rs) bad++;
                if (rw_tr[c] !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_pins: got %0d bad samples expected 0 (m4=%0d b=%h)",
                         bad, m4, b);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        st8 = 1'b0; st4 = 1'b0;
        ce8 = 1'b0; ce4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        clear_ctl();
        test_reset();
        test_cmd8();
        test_clear_wait();
        test_4bit();
        test_busy();
        test_stall();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
